// File: rtl/lcd_char_ctrl.sv
// Character LCD write controller: power-up init, cursor-tracked character writes, 8- or 4-bit bus.
// Defining LCD_CLEAR_EN adds the clr_req input for run-time display clears.
module lcd_char_ctrl #(
   parameter int COUNT_MAX  = 8,
   parameter int BUS_4BIT   = 0,
   parameter int ROWS       = 2,
   parameter int COLS       = 16,
   parameter int INIT_WAIT  = 1000,
   parameter int CLEAR_WAIT = 100
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       wr_valid,
   output logic       wr_ready,
   input  logic       wr_row,
   input  logic [5:0] wr_col,
   input  logic [7:0] wr_char,
`ifdef LCD_CLEAR_EN
   input  logic       clr_req,
`endif
   output logic       rs,
   output logic       rw,
   output logic       enable,
   output logic [7:0] data,
   output logic       init_done,
   output logic       err
);

   typedef enum logic [2:0] {
      RST_WAIT, INIT, IDLE, SET_ADDR, WR_CHAR, CLR_WAIT
   } state_t;

   localparam logic        IS4        = (BUS_4BIT != 0);
   localparam logic [7:0]  FUNC_SET   = IS4 ? 8'h28 : 8'h38;
   localparam logic [2:0]  FIRST_STEP = IS4 ? 3'd0 : 3'd1;
   localparam logic [2:0]  LAST_STEP  = 3'd3;
   localparam logic [31:0] PH_LAST    = 32'(COUNT_MAX - 1);

   state_t      state_r;
   logic [31:0] cnt_r;
   logic [1:0]  phase_r;
   logic        busy_r;
   logic        nib_r;
   logic        single_r;
   logic [3:0]  lo_nib_r;
   logic [2:0]  step_r;
   logic [6:0]  cursor_r;
   logic        cur_valid_r;
   logic [6:0]  addr_r;
   logic [5:0]  col_r;
   logic [7:0]  char_r;
   logic        rs_r;
   logic        enable_r;
   logic [7:0]  data_r;
   logic        wr_ready_r;
   logic        init_done_r;
   logic        err_r;

   logic        phase_end_s;
   logic        last_nib_s;
   logic        xfer_done_s;
   logic        init_end_s;
   logic        clear_end_s;
   logic [6:0]  req_addr_s;
   logic        req_bad_s;
   logic        req_hit_s;
   logic        take_s;
   logic        clr_take_s;
   logic        ld_s;
   logic [7:0]  ld_byte_s;
   logic        ld_rs_s;
   logic        ld_single_s;

   function automatic logic [7:0] first_bus(input logic [7:0] b);
      return IS4 ? {b[7:4], 4'h0} : b;
   endfunction

   function automatic logic [7:0] init_byte(input logic [2:0] step);
      logic [7:0] b;
      case (step)
         3'd0:    b = 8'h20;
         3'd1:    b = FUNC_SET;
         3'd2:    b = 8'h0C;
         3'd3:    b = 8'h06;
         default: b = 8'h01;
      endcase
      return b;
   endfunction

   assign phase_end_s = (cnt_r == PH_LAST);
   assign last_nib_s  = !IS4 || nib_r || single_r;
   assign xfer_done_s = busy_r && phase_end_s && (phase_r == 2'd2) && last_nib_s;
   assign init_end_s  = ((cnt_r + 32'd1) >= 32'(INIT_WAIT));
   assign clear_end_s = !busy_r && ((cnt_r + 32'd1) >= 32'(CLEAR_WAIT));
   assign req_addr_s  = {wr_row, 6'd0} + {1'b0, wr_col};
   assign req_bad_s   = (32'(wr_col) >= 32'(COLS)) || ((ROWS == 1) && wr_row);
   assign req_hit_s   = cur_valid_r && (req_addr_s == cursor_r);
   assign take_s      = wr_valid && wr_ready;

`ifdef LCD_CLEAR_EN
   assign clr_take_s = clr_req;
`else
   assign clr_take_s = 1'b0;
`endif

   // A pending clear hides the write port so the clear always wins.
   assign wr_ready  = wr_ready_r && !clr_take_s;
   assign rs        = rs_r;
   assign rw        = 1'b0;
   assign enable    = enable_r;
   assign data      = data_r;
   assign init_done = init_done_r;
   assign err       = err_r;

   // Selects the byte that starts the next bus transfer, chained straight off the previous one.
   always_comb begin
      ld_s        = 1'b0;
      ld_byte_s   = 8'h00;
      ld_rs_s     = 1'b0;
      ld_single_s = 1'b0;
      case (state_r)
         RST_WAIT: begin
            ld_s        = init_end_s;
            ld_byte_s   = init_byte(FIRST_STEP);
            ld_single_s = IS4;
         end
         INIT: begin
            ld_s      = xfer_done_s;
            ld_byte_s = init_byte(step_r + 3'd1);
         end
         IDLE: begin
            if (clr_take_s) begin
               ld_s      = 1'b1;
               ld_byte_s = 8'h01;
            end else begin
               ld_s      = take_s && !req_bad_s;
               ld_byte_s = req_hit_s ? wr_char : {1'b1, req_addr_s};
               ld_rs_s   = req_hit_s;
            end
         end
         SET_ADDR: begin
            ld_s      = xfer_done_s;
            ld_byte_s = char_r;
            ld_rs_s   = 1'b1;
         end
         default: begin
            ld_s = 1'b0;
         end
      endcase
   end

   // Controller FSM with the setup/strobe/hold transfer engine and all registered outputs.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r     <= RST_WAIT;
         cnt_r       <= 32'd0;
         phase_r     <= 2'd0;
         busy_r      <= 1'b0;
         nib_r       <= 1'b0;
         single_r    <= 1'b0;
         lo_nib_r    <= 4'h0;
         step_r      <= 3'd0;
         cursor_r    <= 7'd0;
         cur_valid_r <= 1'b0;
         addr_r      <= 7'd0;
         col_r       <= 6'd0;
         char_r      <= 8'h00;
         rs_r        <= 1'b0;
         enable_r    <= 1'b0;
         data_r      <= 8'h00;
         wr_ready_r  <= 1'b0;
         init_done_r <= 1'b0;
         err_r       <= 1'b0;
      end else begin
         err_r <= 1'b0;
         if (ld_s) begin
            data_r   <= first_bus(ld_byte_s);
            lo_nib_r <= ld_byte_s[3:0];
            rs_r     <= ld_rs_s;
            single_r <= ld_single_s;
            busy_r   <= 1'b1;
            nib_r    <= 1'b0;
            phase_r  <= 2'd0;
            cnt_r    <= 32'd0;
            enable_r <= 1'b0;
         end else if (busy_r) begin
            if (phase_end_s) begin
               cnt_r <= 32'd0;
               case (phase_r)
                  2'd0: begin
                     phase_r  <= 2'd1;
                     enable_r <= 1'b1;
                  end
                  2'd1: begin
                     phase_r  <= 2'd2;
                     enable_r <= 1'b0;
                  end
                  default: begin
                     phase_r <= 2'd0;
                     if (!last_nib_s) begin
                        nib_r  <= 1'b1;
                        data_r <= {lo_nib_r, 4'h0};
                     end else begin
                        busy_r <= 1'b0;
                     end
                  end
               endcase
            end else begin
               cnt_r <= cnt_r + 32'd1;
            end
         end else if ((state_r == RST_WAIT) || (state_r == CLR_WAIT)) begin
            cnt_r <= cnt_r + 32'd1;
         end else begin
            cnt_r <= 32'd0;
         end

         case (state_r)
            RST_WAIT: begin
               if (init_end_s) begin
                  state_r <= INIT;
                  step_r  <= FIRST_STEP;
               end else begin
                  state_r <= RST_WAIT;
               end
            end
            INIT: begin
               if (xfer_done_s) begin
                  if (step_r == LAST_STEP) begin
                     state_r <= CLR_WAIT;
                  end else begin
                     step_r <= step_r + 3'd1;
                  end
               end else begin
                  state_r <= INIT;
               end
            end
            IDLE: begin
               if (clr_take_s) begin
                  state_r    <= CLR_WAIT;
                  wr_ready_r <= 1'b0;
               end else if (take_s) begin
                  wr_ready_r <= 1'b0;
                  if (req_bad_s) begin
                     err_r <= 1'b1;
                  end else begin
                     addr_r  <= req_addr_s;
                     col_r   <= wr_col;
                     char_r  <= wr_char;
                     state_r <= req_hit_s ? WR_CHAR : SET_ADDR;
                  end
               end else begin
                  wr_ready_r <= 1'b1;
               end
            end
            SET_ADDR: begin
               if (xfer_done_s) begin
                  state_r <= WR_CHAR;
               end else begin
                  state_r <= SET_ADDR;
               end
            end
            WR_CHAR: begin
               if (xfer_done_s) begin
                  state_r    <= IDLE;
                  wr_ready_r <= 1'b1;
                  // The display's auto-increment wraps unpredictably past the last column.
                  if (32'(col_r) == 32'(COLS - 1)) begin
                     cur_valid_r <= 1'b0;
                  end else begin
                     cursor_r    <= addr_r + 7'd1;
                     cur_valid_r <= 1'b1;
                  end
               end else begin
                  state_r <= WR_CHAR;
               end
            end
            CLR_WAIT: begin
               if (clear_end_s) begin
                  state_r     <= IDLE;
                  init_done_r <= 1'b1;
                  wr_ready_r  <= 1'b1;
                  cur_valid_r <= 1'b0;
               end else begin
                  state_r <= CLR_WAIT;
               end
            end
            default: begin
               state_r <= RST_WAIT;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_lcd_char_ctrl.sv
// Directed bench for lcd_char_ctrl: an 8-bit instance (a) and a 4-bit single-row instance (b).
`timescale 1ns/1ps
module tb_lcd_char_ctrl;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int total = 0;
   int bad   = 0;

   logic       a_reset, a_valid, a_ready, a_row, a_rs, a_rw, a_en, a_done, a_err;
   logic [5:0] a_col;
   logic [7:0] a_char, a_data;
   logic       b_reset, b_valid, b_ready, b_row, b_rs, b_rw, b_en, b_done, b_err;
   logic [5:0] b_col;
   logic [7:0] b_char, b_data;
`ifdef LCD_CLEAR_EN
   logic       a_clr = 1'b0;
   logic       b_clr = 1'b0;
`endif

   lcd_char_ctrl #(.COUNT_MAX(8), .BUS_4BIT(0), .ROWS(2), .COLS(16), .INIT_WAIT(20), .CLEAR_WAIT(10)) dut_a (
      .clk(clk), .reset(a_reset), .wr_valid(a_valid), .wr_ready(a_ready), .wr_row(a_row),
      .wr_col(a_col), .wr_char(a_char),
`ifdef LCD_CLEAR_EN
      .clr_req(a_clr),
`endif
      .rs(a_rs), .rw(a_rw), .enable(a_en), .data(a_data), .init_done(a_done), .err(a_err));

   lcd_char_ctrl #(.COUNT_MAX(2), .BUS_4BIT(1), .ROWS(1), .COLS(8), .INIT_WAIT(4), .CLEAR_WAIT(3)) dut_b (
      .clk(clk), .reset(b_reset), .wr_valid(b_valid), .wr_ready(b_ready), .wr_row(b_row),
      .wr_col(b_col), .wr_char(b_char),
`ifdef LCD_CLEAR_EN
      .clr_req(b_clr),
`endif
      .rs(b_rs), .rw(b_rw), .enable(b_en), .data(b_data), .init_done(b_done), .err(b_err));

   // Strobe logs: {rs,data} at each enable rise, the rise cycle, and the high width.
   logic [8:0] qa[$];
   int         qa_t[$];
   int         qa_w[$];
   logic [8:0] qb[$];
   int         qb_t[$];
   int         qb_w[$];
   logic       a_en_q = 1'b0, b_en_q = 1'b0;
   logic [8:0] a_hold = 9'h000, b_hold = 9'h000;
   int         a_w = 0, b_w = 0, unstable = 0, rw_bad = 0;

   // Bus monitor for instance a.
   always @(negedge clk) begin
      if (a_en && !a_en_q) begin
         qa.push_back({a_rs, a_data});
         qa_t.push_back(cyc);
         a_w    <= 1;
         a_hold <= {a_rs, a_data};
      end else if (a_en) begin
         a_w <= a_w + 1;
         if ({a_rs, a_data} !== a_hold) unstable <= unstable + 1;
      end else if (a_en_q) begin
         qa_w.push_back(a_w);
      end
      if (a_rw !== 1'b0 || b_rw !== 1'b0) rw_bad <= rw_bad + 1;
      a_en_q <= a_en;
   end

   // Bus monitor for instance b.
   always @(negedge clk) begin
      if (b_en && !b_en_q) begin
         qb.push_back({b_rs, b_data});
         qb_t.push_back(cyc);
         b_w    <= 1;
         b_hold <= {b_rs, b_data};
      end else if (b_en) begin
         b_w <= b_w + 1;
         if ({b_rs, b_data} !== b_hold) unstable <= unstable + 1;
      end else if (b_en_q) begin
         qb_w.push_back(b_w);
      end
      b_en_q <= b_en;
   end

   function automatic logic [31:0] ga(input int i);  return (i < qa.size())   ? 32'(qa[i])   : 32'hFFFF_FFFF; endfunction
   function automatic logic [31:0] gat(input int i); return (i < qa_t.size()) ? 32'(qa_t[i]) : 32'hFFFF_FFFF; endfunction
   function automatic logic [31:0] gaw(input int i); return (i < qa_w.size()) ? 32'(qa_w[i]) : 32'hFFFF_FFFF; endfunction
   function automatic logic [31:0] gb(input int i);  return (i < qb.size())   ? 32'(qb[i])   : 32'hFFFF_FFFF; endfunction
   function automatic logic [31:0] gbt(input int i); return (i < qb_t.size()) ? 32'(qb_t[i]) : 32'hFFFF_FFFF; endfunction
   function automatic logic [31:0] gbw(input int i); return (i < qb_w.size()) ? 32'(qb_w[i]) : 32'hFFFF_FFFF; endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic clr_logs();
      qa.delete(); qa_t.delete(); qa_w.delete();
      qb.delete(); qb_t.delete(); qb_w.delete();
   endtask

   task automatic a_wait(input string tag, input int lim);
      int n = 0;
      while (a_ready !== 1'b1 && n < lim) begin tick(1); n++; end
      chk(tag, a_ready, 1'b1);
   endtask

   task automatic b_wait(input string tag, input int lim);
      int n = 0;
      while (b_ready !== 1'b1 && n < lim) begin tick(1); n++; end
      chk(tag, b_ready, 1'b1);
   endtask

   task automatic a_write(input logic row, input logic [5:0] col, input logic [7:0] ch, output int hs);
      a_row = row; a_col = col; a_char = ch; a_valid = 1'b1;
      tick(1);
      hs = cyc;
      a_valid = 1'b0;
      chk("a_ready_drop", a_ready, 1'b0);
   endtask

   task automatic b_write(input logic row, input logic [5:0] col, input logic [7:0] ch, output int hs);
      b_row = row; b_col = col; b_char = ch; b_valid = 1'b1;
      tick(1);
      hs = cyc;
      b_valid = 1'b0;
      chk("b_ready_drop", b_ready, 1'b0);
   endtask

   task automatic a_check_init(input int r, input string pre);
      logic [8:0] exp_a [4] = '{9'h038, 9'h00C, 9'h006, 9'h001};
      int n = 0;
      while (a_done !== 1'b1 && n < 500) begin tick(1); n++; end
      chk({pre, "_done_cycles"}, cyc - r, 126);
      chk({pre, "_count"}, qa.size(), 4);
      chk({pre, "_first_rise"}, gat(0) - r, 28);
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("%s_byte%0d", pre, i), ga(i), exp_a[i]);
         chk($sformatf("%s_width%0d", pre, i), gaw(i), 8);
      end
      for (int i = 0; i < 3; i++) chk($sformatf("%s_gap%0d", pre, i), gat(i + 1) - gat(i), 24);
      chk({pre, "_ready"}, a_ready, 1'b1);
   endtask

   initial begin
      int r, hs, hs2, n;
      logic [8:0] exp_b [9] = '{9'h020, 9'h020, 9'h080, 9'h000, 9'h0C0, 9'h000, 9'h060, 9'h000, 9'h010};
      a_reset = 1'b0; a_valid = 1'b0; a_row = 1'b0; a_col = 6'd0; a_char = 8'h00;
      b_reset = 1'b0; b_valid = 1'b0; b_row = 1'b0; b_col = 6'd0; b_char = 8'h00;
      tick(3);
      chk("rst_rs", a_rs, 1'b0);
      chk("rst_rw", a_rw, 1'b0);
      chk("rst_enable", a_en, 1'b0);
      chk("rst_data", a_data, 8'h00);
      chk("rst_ready", a_ready, 1'b0);
      chk("rst_init_done", a_done, 1'b0);
      chk("rst_err", a_err, 1'b0);

      a_reset = 1'b1; r = cyc;
      a_check_init(r, "a_init");
      clr_logs();

      a_write(1'b1, 6'd3, 8'h41, hs);
      a_wait("a_ready_after_A", 200);
      a_write(1'b1, 6'd4, 8'h42, hs2);
      a_wait("a_ready_after_B", 200);
      chk("ab_count", qa.size(), 3);
      chk("ab_addr", ga(0), 9'h0C3);
      chk("ab_char_A", ga(1), 9'h141);
      chk("ab_char_B", ga(2), 9'h142);
      chk("ab_latency", gat(0) - hs, 8);
      chk("ab_gap", gat(1) - gat(0), 24);
      chk("ab_b_latency", gat(2) - hs2, 8);
      clr_logs();

      a_write(1'b0, 6'd15, 8'h5A, hs);
      a_wait("a_ready_after_c15", 200);
      chk("c15_count", qa.size(), 2);
      chk("c15_addr", ga(0), 9'h08F);
      chk("c15_char", ga(1), 9'h15A);
      clr_logs();

      a_write(1'b0, 6'd16, 8'h33, hs);
      chk("oor_err_hi", a_err, 1'b1);
      tick(1);
      chk("oor_err_lo", a_err, 1'b0);
      chk("oor_ready_back", a_ready, 1'b1);
      tick(30);
      chk("oor_no_bus", qa.size(), 0);

`ifdef LCD_CLEAR_EN
      clr_logs();
      a_clr = 1'b1; a_row = 1'b0; a_col = 6'd5; a_char = 8'h55; a_valid = 1'b1;
      tick(1);
      a_clr = 1'b0;
      chk("clr_ready_low", a_ready, 1'b0);
      a_wait("clr_ready_back", 300);
      tick(1);
      a_valid = 1'b0;
      a_wait("clr_write_done", 300);
      chk("clr_count", qa.size(), 3);
      chk("clr_cmd", ga(0), 9'h001);
      chk("clr_addr", ga(1), 9'h085);
      chk("clr_char", ga(2), 9'h155);
`endif

      a_reset = 1'b0;
      tick(2);
      clr_logs();
      a_reset = 1'b1; r = cyc;
      n = 0;
      while (qa.size() < 2 && n < 200) begin tick(1); n++; end
      tick(2);
      chk("mid_in_strobe", {a_en, a_data}, 9'h10C);
      a_reset = 1'b0;
      #1;
      chk("mid_enable", a_en, 1'b0);
      chk("mid_data", a_data, 8'h00);
      chk("mid_rs", a_rs, 1'b0);
      chk("mid_init_done", a_done, 1'b0);
      tick(2);
      clr_logs();
      a_reset = 1'b1; r = cyc;
      a_check_init(r, "a_reinit");

      b_reset = 1'b1; r = cyc;
      n = 0;
      while (b_done !== 1'b1 && n < 300) begin tick(1); n++; end
      chk("b_done_cycles", cyc - r, 61);
      chk("b_count", qb.size(), 9);
      chk("b_first_rise", gbt(0) - r, 6);
      for (int i = 0; i < 9; i++) begin
         chk($sformatf("b_nib%0d", i), gb(i), exp_b[i]);
         chk($sformatf("b_width%0d", i), gbw(i), 2);
      end
      clr_logs();
      b_write(1'b0, 6'd0, 8'h5A, hs);
      b_wait("b_ready_after_5A", 200);
      chk("b5a_count", qb.size(), 4);
      chk("b5a_addr_hi", gb(0), 9'h080);
      chk("b5a_addr_lo", gb(1), 9'h000);
      chk("b5a_char_hi", gb(2), 9'h150);
      chk("b5a_char_lo", gb(3), 9'h1A0);
      chk("b5a_latency", gbt(0) - hs, 2);
      clr_logs();
      b_write(1'b1, 6'd0, 8'h41, hs);
      chk("b_row1_err", b_err, 1'b1);
      tick(20);
      chk("b_row1_no_bus", qb.size(), 0);
      chk("b_row1_ready", b_ready, 1'b1);

      chk("strobe_stable", unstable, 0);
      chk("rw_low", rw_bad, 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/lcd_char_ctrl.md
LCD_CHAR_CTRL -- requirements
Module: lcd_char_ctrl

Interface
REQ-001 SHALL have parameter COUNT_MAX, default 8: clk cycles per bus phase (setup, enable-high, hold); legal range 2..65535.
REQ-002 SHALL have parameter BUS_4BIT, default 0: 0 = 8-bit data bus, 1 = 4-bit data bus on data[7:4].
REQ-003 SHALL have parameter ROWS, default 2 (legal 1 or 2); parameter COLS, default 16 (legal 1..40).
REQ-004 SHALL have parameter INIT_WAIT, default 1000: power-up wait in clk cycles; parameter CLEAR_WAIT, default 100: extra wait after a 0x01 command.
REQ-005 SHALL have ports, clock and reset first: clk in 1 system clock; reset in 1 asynchronous active-low reset.
REQ-006 SHALL have ports wr_valid in 1 char request; wr_ready out 1 ready to accept; wr_row in 1 row index; wr_col in 6 column index; wr_char in 8 character code.
REQ-007 SHALL have ports rs out 1 register select; rw out 1 read/write (always 0); enable out 1 LCD strobe; data out 8 LCD bus; init_done out 1 init complete; err out 1 one-cycle out-of-range pulse.

Function
REQ-008 SHALL be the only clock domain: clk, reset asynchronous active-low; all other logic synchronous to rising clk.
REQ-009 SHALL implement states RST_WAIT, INIT, IDLE, SET_ADDR, WR_CHAR, CLR_WAIT.
REQ-010 SHALL stay in RST_WAIT for INIT_WAIT cycles after reset release, then enter INIT.
REQ-011 SHALL issue in INIT, in order: 4-bit mode only, single nibble 0x2; function set (0x38 if BUS_4BIT=0, 0x28 if 1); 0x0C; 0x06; 0x01 followed by CLEAR_WAIT cycles; then assert init_done and enter IDLE.
REQ-012 SHALL run each bus transfer as three phases of COUNT_MAX cycles each: setup (enable=0, rs/data stable), strobe (enable=1), hold (enable=0, rs/data unchanged); one transfer = 3*COUNT_MAX cycles.
REQ-013 SHALL, with BUS_4BIT=1, send each byte as two transfers, high nibble first, on data[7:4], with data[3:0]=0.
REQ-014 SHALL drive wr_ready=1 only in IDLE; handshake completes on a clk edge where wr_valid=1 and wr_ready=1; request fields are captured on that edge and wr_ready drops on the next cycle.
REQ-015 SHALL compute DDRAM address = wr_col + (wr_row ? 0x40 : 0x00).
REQ-016 SHALL, if wr_col >= COLS or (ROWS=1 and wr_row=1), accept the request, pulse err for one cycle, produce no bus activity, and return to IDLE.
REQ-017 SHALL track the cursor: if the captured address equals the current cursor, skip SET_ADDR; otherwise send 0x80|address (rs=0) and then the character (rs=1).
REQ-018 SHALL advance the cursor by 1 after each character; after writing column COLS-1, mark the cursor invalid so the next write always sends SET_ADDR.
REQ-019 SHALL mark the cursor invalid after a 0x01 command.
REQ-020 SHALL hold rw=0 at all times.

Reset
REQ-021 SHALL, while reset=0, force immediately: rs=0, rw=0, enable=0, data=0x00, wr_ready=0, init_done=0, err=0, state RST_WAIT, cursor invalid, counters 0.
REQ-022 SHALL, on reset assertion mid-transfer, abandon the transfer and, after release, rerun the full RST_WAIT and INIT sequence.

Configuration
REQ-023 SHALL honour macro LCD_CLEAR_EN: when defined, add input clr_req (1 bit) sampled in IDLE; clr_req has priority over wr_valid, wr_ready is 0 while a clear is pending, and the block sends 0x01 then CLEAR_WAIT cycles via CLR_WAIT before returning to IDLE.
REQ-024 SHALL, without LCD_CLEAR_EN, have no clr_req port and no clear path after INIT.

Verification
REQ-025 SHALL cover power-up with COUNT_MAX=8, BUS_4BIT=0, INIT_WAIT=20: enable stays 0 for 20 cycles, then bytes 0x38, 0x0C, 0x06, 0x01 each with enable high 8 cycles, then init_done=1.
REQ-026 SHALL cover writing 'A' (0x41) at row 1, col 3, then 'B' at row 1, col 4: bus shows 0xC3 (rs=0), 0x41 (rs=1), 0x42 (rs=1), with no second address command.
REQ-027 SHALL cover BUS_4BIT=1 writing 0x5A at row 0, col 0 after init: nibbles 0x8, 0x0 (rs=0), then 0x5, 0xA (rs=1) on data[7:4], with data[3:0]=0.
REQ-028 SHALL cover wr_col=16 with COLS=16: err pulses for exactly one cycle, enable stays 0, and wr_ready returns to 1.
REQ-029 SHALL cover reset pulled low during the strobe phase of the 0x0C command: enable=0 immediately, and after release the full init sequence restarts from 0x38.
REQ-030 SHALL cover, with LCD_CLEAR_EN, clr_req and wr_valid asserted together: 0x01 is sent first, then SET_ADDR and the character.
